// File: rtl/tracker_pkg.sv
// Shared types and constants for the tracker sequencer and its helpers.
package tracker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT,
    ST_PAUSE
  } seq_state_t;

  localparam int DEFAULT_DATA_W = 16;
  // A cell holding this value is an empty slot and never triggers a note.
  localparam int EMPTY_NOTE     = 0;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that wraps every TICK_DIV enabled cycles and flags the wrap cycle.
module tick_prescaler #(
  parameter int TICK_DIV = 250000
) (
  input  logic clk,
  input  logic rst_active_low,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  // tick marks the enabled cycle whose closing edge performs the wrap.
  assign tick = enable && (count_q == LAST_COUNT);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == LAST_COUNT) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_active_low) begin
    if (!rst_active_low) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tracker_sequencer.sv
// Phrase playback sequencer: walks phrase rows at a tick-based tempo and
// issues per-channel note triggers, with pause/resume, stop and looping.
module tracker_sequencer
  import tracker_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ROWS     = 16,
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int TICK_DIV = 250000,
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_active_low,
  input  logic                     play_toggle,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic [7:0]               ticks_per_row,
  input  logic [NUM_CH-1:0]        mute,
  output logic [RW-1:0]            row_addr,
  input  logic [NUM_CH*DATA_W-1:0] row_data,
  output logic [NUM_CH*DATA_W-1:0] note_data,
  output logic [NUM_CH-1:0]        note_valid,
  output logic                     tick,
  output logic                     playing,
  output logic                     phrase_end
);

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  seq_state_t               state_q, state_d;
  logic [RW-1:0]            row_q, row_d;
  logic [7:0]               tpr_q, tpr_d;
  logic [7:0]               tick_cnt_q, tick_cnt_d;
  logic [NUM_CH*DATA_W-1:0] note_data_q, note_data_d;
  logic [NUM_CH-1:0]        note_valid_q, note_valid_d;
  logic                     tick_q;
  logic                     playing_q, playing_d;
  logic                     phrase_end_q, phrase_end_d;

  logic presc_en, presc_clr, presc_tick, last_tick;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge rst_active_low) begin
    if (!rst_active_low) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  assign presc_en  = (state_q == ST_WAIT) && !stop;
  assign presc_clr = (state_q == ST_ISSUE) || stop;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk           (clk),
    .rst_active_low(rst_n),
    .enable        (presc_en),
    .clear         (presc_clr),
    .tick          (presc_tick)
  );

  assign last_tick = presc_tick && (tick_cnt_q == tpr_q - 8'd1);

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    tpr_d        = tpr_q;
    tick_cnt_d   = tick_cnt_q;
    note_data_d  = note_data_q;
    note_valid_d = '0;
    phrase_end_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        row_d = '0;
        if (play_toggle) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_ISSUE;
      ST_ISSUE: begin
        note_data_d = row_data;
        for (int c = 0; c < NUM_CH; c++) begin
          note_valid_d[c] = !mute[c] &&
                            (row_data[c*DATA_W +: DATA_W] != DATA_W'(EMPTY_NOTE));
        end
        tpr_d      = (ticks_per_row == 8'd0) ? 8'd1 : ticks_per_row;
        tick_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // The row-ending tick takes priority over a pause request.
        if (last_tick) begin
          tick_cnt_d = '0;
          if (row_q != LAST_ROW) begin
            row_d   = row_q + 1'b1;
            state_d = ST_FETCH;
          end else begin
            row_d        = '0;
            phrase_end_d = 1'b1;
            state_d      = loop_en ? ST_FETCH : ST_IDLE;
          end
        end else begin
          if (presc_tick) tick_cnt_d = tick_cnt_q + 8'd1;
          if (play_toggle) state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (play_toggle) state_d = ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase

    if (stop) begin
      state_d      = ST_IDLE;
      row_d        = '0;
      tick_cnt_d   = '0;
      note_data_d  = note_data_q;
      note_valid_d = '0;
      phrase_end_d = 1'b0;
    end

    playing_d = (state_d == ST_FETCH) || (state_d == ST_ISSUE) || (state_d == ST_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      tpr_q        <= '0;
      tick_cnt_q   <= '0;
      note_data_q  <= '0;
      note_valid_q <= '0;
      tick_q       <= 1'b0;
      playing_q    <= 1'b0;
      phrase_end_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      tpr_q        <= tpr_d;
      tick_cnt_q   <= tick_cnt_d;
      note_data_q  <= note_data_d;
      note_valid_q <= note_valid_d;
      tick_q       <= presc_tick;
      playing_q    <= playing_d;
      phrase_end_q <= phrase_end_d;
    end
  end

  assign row_addr   = row_q;
  assign note_data  = note_data_q;
  assign note_valid = note_valid_q;
  assign tick       = tick_q;
  assign playing    = playing_q;
  assign phrase_end = phrase_end_q;

endmodule

// File: tb/tb_tracker_sequencer.sv
// Bench for tracker_sequencer: directed scenario tables plus randomized play
// checked cycle-by-cycle against a row-timeline reference model.
module tb_tracker_sequencer;

  localparam int NUM_CH   = 4;
  localparam int ROWS     = 4;
  localparam int DATA_W   = 16;
  localparam int TICK_DIV = 4;

  logic        clk;
  logic        rstN;
  logic        playToggle;
  logic        stop;
  logic        loopEn;
  logic [7:0]  ticksPerRow;
  logic [3:0]  mute;
  logic [1:0]  rowAddr;
  logic [63:0] rowData;
  logic [63:0] noteData;
  logic [3:0]  noteValid;
  logic        tick;
  logic        playing;
  logic        phraseEnd;

  tracker_sequencer #(
    .NUM_CH  (NUM_CH),
    .ROWS    (ROWS),
    .DATA_W  (DATA_W),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk           (clk),
    .rst_active_low(rstN),
    .play_toggle   (playToggle),
    .stop          (stop),
    .loop_en       (loopEn),
    .ticks_per_row (ticksPerRow),
    .mute          (mute),
    .row_addr      (rowAddr),
    .row_data      (rowData),
    .note_data     (noteData),
    .note_valid    (noteValid),
    .tick          (tick),
    .playing       (playing),
    .phrase_end    (phraseEnd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Row r holds {ch3, ch2, ch1, ch0} = {r+1, r+1, 0, r+1}.
  function automatic logic [63:0] rowWord(input int r);
    logic [15:0] v;
    v = 16'(r + 1);
    return {v, v, 16'h0000, v};
  endfunction

  // Phrase storage with one cycle of read latency.
  always @(posedge clk) rowData <= rowWord(int'(rowAddr));

  int compared;
  int mismatched;
  int cyc;

  logic [3:0]  obsNv   [0:255];
  logic        obsPe   [0:255];
  logic        obsPlay [0:255];
  logic [1:0]  obsAddr [0:255];
  logic        obsTick [0:255];
  logic [63:0] obsData [0:255];

  bit togSched  [0:255];
  bit stopSched [0:255];

  typedef struct {
    string       name;
    int          cyc;
    int          field;
    logic [63:0] val;
  } vec_t;
  vec_t vecs[$];

  // Reference model: a row is a timeline of ages (0 fetch, 1 issue, then
  // T*TICK_DIV waiting cycles); paused cycles do not age the row.
  int          mMode;
  int          mRow;
  int          mAge;
  int          mT;
  logic [63:0] mNoteData;
  logic [3:0]  mNv;
  bit          mTick;
  bit          mPe;

  task automatic modelReset();
    mMode = 0; mRow = 0; mAge = 0; mT = 1;
    mNoteData = '0; mNv = '0; mTick = 0; mPe = 0;
  endtask

  task automatic modelEdge();
    int waited;
    mNv = '0; mTick = 0; mPe = 0;
    if (stop) begin
      mMode = 0;
      mRow  = 0;
    end else if (mMode == 0) begin
      if (playToggle) begin
        mMode = 1;
        mAge  = 0;
      end
    end else if (mMode == 1) begin
      if (mAge == 0) begin
        mAge = 1;
      end else if (mAge == 1) begin
        mT        = (ticksPerRow == 0) ? 1 : int'(ticksPerRow);
        mNoteData = rowWord(mRow);
        for (int c = 0; c < NUM_CH; c++)
          mNv[c] = !mute[c] && (mNoteData[c*DATA_W +: DATA_W] != 0);
        mAge = 2;
      end else begin
        waited = mAge - 1;
        if (waited % TICK_DIV == 0) mTick = 1;
        if (waited == mT * TICK_DIV) begin
          mAge = 0;
          if (mRow < ROWS - 1) begin
            mRow++;
          end else begin
            mPe  = 1;
            mRow = 0;
            if (!loopEn) mMode = 0;
          end
        end else begin
          mAge++;
          if (playToggle) mMode = 2;
        end
      end
    end else begin
      if (playToggle) mMode = 1;
    end
  endtask

  task automatic cmp(input string name, input int atCyc,
                     input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", name, atCyc, act, exp);
    end
  endtask

  task automatic checkOutput();
    cmp("row_addr",   cyc, 64'(rowAddr),   64'(mRow));
    cmp("note_valid", cyc, 64'(noteValid), 64'(mNv));
    cmp("note_data",  cyc, noteData,       mNoteData);
    cmp("tick",       cyc, 64'(tick),      64'(mTick));
    cmp("playing",    cyc, 64'(playing),   64'(mMode == 1));
    cmp("phrase_end", cyc, 64'(phraseEnd), 64'(mPe));
  endtask

  // Advance one clock: the edge samples the currently driven inputs.
  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    #1;
    cyc++;
    if (cyc < 256) begin
      obsNv[cyc]   = noteValid;
      obsPe[cyc]   = phraseEnd;
      obsPlay[cyc] = playing;
      obsAddr[cyc] = rowAddr;
      obsTick[cyc] = tick;
      obsData[cyc] = noteData;
    end
    checkOutput();
  endtask

  task automatic clearSched();
    for (int i = 0; i < 256; i++) begin
      togSched[i]  = 0;
      stopSched[i] = 0;
    end
  endtask

  task automatic doReset();
    rstN = 1'b0; playToggle = 1'b0; stop = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    repeat (3) applyStimulus();
    cyc = 0;
    obsNv[0] = noteValid; obsPe[0] = phraseEnd; obsPlay[0] = playing;
    obsAddr[0] = rowAddr; obsTick[0] = tick; obsData[0] = noteData;
    clearSched();
  endtask

  task automatic runScenario(input int n);
    for (int i = 0; i < n; i++) begin
      playToggle = togSched[cyc];
      stop       = stopSched[cyc];
      applyStimulus();
    end
    playToggle = 1'b0;
    stop       = 1'b0;
  endtask

  task automatic addVec(input string name, input int at, input int field, input logic [63:0] val);
    vecs.push_back('{name, at, field, val});
  endtask

  function automatic logic [63:0] obsField(input int field, input int at);
    case (field)
      0:       return 64'(obsNv[at]);
      1:       return 64'(obsPe[at]);
      2:       return 64'(obsPlay[at]);
      3:       return 64'(obsAddr[at]);
      4:       return 64'(obsTick[at]);
      default: return obsData[at];
    endcase
  endfunction

  task automatic checkVecs();
    for (int i = 0; i < vecs.size(); i++)
      cmp(vecs[i].name, vecs[i].cyc, obsField(vecs[i].field, vecs[i].cyc), vecs[i].val);
    vecs.delete();
  endtask

  int quietCount;

  initial begin
    compared = 0; mismatched = 0; cyc = 0;
    rstN = 1'b1; playToggle = 1'b0; stop = 1'b0;
    loopEn = 1'b0; ticksPerRow = 8'd2; mute = 4'b0000;
    modelReset();
    #2;

    // Single pass, no loop.
    doReset();
    addVec("reset_playing", 0, 2, 0);
    addVec("reset_addr",    0, 3, 0);
    addVec("s1_nv_row0",    3, 0, 4'b1101);
    addVec("s1_nv_oneshot", 4, 0, 4'b0000);
    addVec("s1_tick_first", 7, 4, 1);
    addVec("s1_nv_row1",   13, 0, 4'b1101);
    addVec("s1_nv_row2",   23, 0, 4'b1101);
    addVec("s1_nv_row3",   33, 0, 4'b1101);
    addVec("s1_addr_row3", 33, 3, 3);
    addVec("s1_pe_early",  40, 1, 0);
    addVec("s1_pe",        41, 1, 1);
    addVec("s1_addr_wrap", 41, 3, 0);
    addVec("s1_idle",      42, 2, 0);
    togSched[0] = 1;
    runScenario(46);
    checkVecs();

    // Looping phrase.
    loopEn = 1'b1;
    doReset();
    addVec("s2_addr_last", 40, 3, 3);
    addVec("s2_pe",        41, 1, 1);
    addVec("s2_addr_zero", 41, 3, 0);
    addVec("s2_nv_again",  43, 0, 4'b1101);
    togSched[0] = 1; stopSched[46] = 1;
    runScenario(50);
    checkVecs();

    // Muted channel 2.
    loopEn = 1'b0; mute = 4'b0100;
    doReset();
    addVec("s3_nv_muted", 3, 0, 4'b1001);
    addVec("s3_data",     3, 5, 64'h0001_0001_0000_0001);
    togSched[0] = 1; stopSched[6] = 1;
    runScenario(8);
    checkVecs();

    // Pause after the first tick for 52 cycles, then resume.
    mute = 4'b0000;
    doReset();
    addVec("s4_nv_not_unpaused", 13, 0, 4'b0000);
    addVec("s4_paused_playing",  30, 2, 0);
    addVec("s4_nv_delayed",      65, 0, 4'b1101);
    togSched[0] = 1; togSched[8] = 1; togSched[60] = 1;
    runScenario(70);
    checkVecs();
    quietCount = 0;
    for (int i = 9; i <= 61; i++) quietCount += int'(obsTick[i]);
    cmp("s4_tick_while_paused", 61, 64'(quietCount), 0);

    // Stop together with play_toggle during row 2.
    doReset();
    addVec("s5_addr_before", 25, 3, 2);
    addVec("s5_addr_after",  26, 3, 0);
    addVec("s5_idle",        26, 2, 0);
    togSched[0] = 1; togSched[25] = 1; stopSched[25] = 1;
    runScenario(60);
    checkVecs();
    quietCount = 0;
    for (int i = 26; i <= 60; i++) quietCount += int'(obsNv[i] != 0) + int'(obsPe[i]);
    cmp("s5_no_pulses", 60, 64'(quietCount), 0);

    // ticks_per_row = 0 behaves as 1, then an asynchronous reset mid-row.
    ticksPerRow = 8'd0;
    doReset();
    addVec("s6_nv_row0",  3, 0, 4'b1101);
    addVec("s6_nv_gap",   8, 0, 4'b0000);
    addVec("s6_nv_row1",  9, 0, 4'b1101);
    addVec("s6_nv_row2", 15, 0, 4'b1101);
    togSched[0] = 1;
    runScenario(17);
    checkVecs();
    #3 rstN = 1'b0;
    #1;
    cmp("s6_rst_playing",    cyc, 64'(playing),   0);
    cmp("s6_rst_addr",       cyc, 64'(rowAddr),   0);
    cmp("s6_rst_note_data",  cyc, noteData,       0);
    cmp("s6_rst_note_valid", cyc, 64'(noteValid), 0);
    cmp("s6_rst_tick",       cyc, 64'(tick),      0);
    cmp("s6_rst_phrase_end", cyc, 64'(phraseEnd), 0);

    // Randomized play against the reference model.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      playToggle = ($urandom_range(0, 9) == 0);
      stop       = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 15) == 0) loopEn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) ticksPerRow = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) mute = 4'($urandom_range(0, 15));
      applyStimulus();
    end
    playToggle = 1'b0;
    stop       = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
